// File: rtl/approx_smul_pkg.sv
// approx_smul_pkg: mode encodings and width helpers shared by the
// approximate signed multiplier pipeline (approx_smul_pipe).
package approx_smul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Full signed product width for a WIDTH x WIDTH multiply.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Number of partial-product bits landing in column c.
    function automatic int col_height(input int w, input int c);
        if (c < 0 || c > 2 * w - 2)
            return 0;
        else if (c < w)
            return c + 1;
        else
            return 2 * w - 1 - c;
    endfunction

endpackage

// File: rtl/approx_smul_pipe_reduce.sv
// approx_pp_reduce: combinational Baugh-Wooley partial-product array
// reduced to two rows (sum, carry). In approximate mode the low
// APPROX_COLS columns are replaced by a per-column OR.
// Ports: x, y (operands), mode, sum, carry (2*WIDTH rows);
// err (exact - approx) only with APPROX_SMUL_ERRSTAT_EN.
module approx_pp_reduce
    import approx_smul_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_COLS = 8
) (
    input  logic [WIDTH-1:0]               x,
    input  logic [WIDTH-1:0]               y,
    input  logic                           mode,
    output logic [prod_width(WIDTH)-1:0]   sum,
    output logic [prod_width(WIDTH)-1:0]   carry
`ifdef APPROX_SMUL_ERRSTAT_EN
    ,
    output logic [prod_width(WIDTH)-1:0]   err
`endif
);

    localparam int PW = prod_width(WIDTH);
    // Baugh-Wooley correction: 2^W + 2^(2W-1).
    localparam logic [PW-1:0] CORR =
        (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
    localparam logic [PW-1:0] LOW =
        (PW'(1) << APPROX_COLS) - PW'(1);

    logic approx;
    assign approx = (mode == MODE_APPROX);

    always_comb begin
        logic [PW-1:0] orv;
        logic [PW-1:0] lsum;
        logic [PW-1:0] row;
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] t;
        logic          b;
        orv  = '0;
        lsum = '0;
        // Low columns never contain sign-position bits, so the
        // OR and the exact low sum use plain AND terms.
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i + j < APPROX_COLS) begin
                    b = x[i] & y[j];
                    orv[i+j] = orv[i+j] | b;
                    lsum = lsum + (PW'(b) << (i + j));
                end
            end
        end
        s = CORR;
        c = approx ? orv : '0;
        for (int j = 0; j < WIDTH; j++) begin
            row = '0;
            for (int i = 0; i < WIDTH; i++) begin
                b = x[i] & y[j];
                // Sign row/column terms are inverted, sign*sign is not.
                if ((i == WIDTH - 1) != (j == WIDTH - 1))
                    b = ~b;
                row[i] = b;
            end
            row = row << j;
            if (approx)
                row = row & ~LOW;
            // 3:2 carry-save step; the carry out of the top is
            // dropped since the product is taken modulo 2^(2W).
            t = s ^ c ^ row;
            c = ((s & c) | (s & row) | (c & row)) << 1;
            s = t;
        end
        sum   = s;
        carry = c;
`ifdef APPROX_SMUL_ERRSTAT_EN
        err   = approx ? (lsum - orv) : '0;
`endif
    end

endmodule

// File: rtl/approx_smul_pipe.sv
// approx_smul_pipe: pipelined signed WIDTH x WIDTH multiplier with
// per-transaction exact/approximate mode and valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_x/in_y/
// in_mode; out_valid/out_ready/out_z/out_mode.
// Option APPROX_SMUL_ERRSTAT_EN adds out_err and err_max.
module approx_smul_pipe
    import approx_smul_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_COLS = 8,
    parameter int STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_z,
    output logic                 out_mode
`ifdef APPROX_SMUL_ERRSTAT_EN
    ,
    output logic [2*WIDTH-1:0]   out_err,
    output logic [2*WIDTH-1:0]   err_max
`endif
);

    localparam int PW   = prod_width(WIDTH);
    localparam int LAST = STAGES - 1;
    // First stage holding the final sum; stage 0 holds the two
    // reduced rows unless the pipe is a single stage.
    localparam int F    = (STAGES == 1) ? 0 : 1;

    logic [PW-1:0]     row_s;
    logic [PW-1:0]     row_c;
    logic [PW-1:0]     sum_in;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] m_q;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] m_in;
    logic [PW-1:0]     z_q [F:LAST];

`ifdef APPROX_SMUL_ERRSTAT_EN
    logic [PW-1:0] err_in;
    logic [PW-1:0] e_q [STAGES];
    logic [PW-1:0] err_abs;
`endif

    approx_pp_reduce #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_reduce (
        .x     (in_x),
        .y     (in_y),
        .mode  (in_mode),
        .sum   (row_s),
        .carry (row_c)
`ifdef APPROX_SMUL_ERRSTAT_EN
        ,
        .err   (err_in)
`endif
    );

    // Stage k can load when it or any stage after it is empty, or
    // the output is being taken: a running OR from the output back.
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            r = r | ~v_q[k];
            ld[k] = r;
        end
    end

    always_comb begin
        v_in[0] = in_valid;
        m_in[0] = in_mode;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            m_in[k] = m_q[k-1];
        end
    end

    // Gated by rst so nothing transfers during the reset cycle.
    assign in_ready  = ld[0] & ~rst;
    assign out_valid = v_q[LAST] & ~rst;
    assign out_z     = z_q[LAST];
    assign out_mode  = m_q[LAST];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            m_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k])
                    v_q[k] <= v_in[k];
                if (ld[k] && v_in[k])
                    m_q[k] <= m_in[k];
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            assign sum_in = row_s + row_c;
        end else begin : g_rows
            logic [PW-1:0] s_q;
            logic [PW-1:0] c_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q <= '0;
                    c_q <= '0;
                end else if (ld[0] && in_valid) begin
                    s_q <= row_s;
                    c_q <= row_c;
                end
            end
            assign sum_in = s_q + c_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = F; k <= LAST; k++)
                z_q[k] <= '0;
        end else begin
            if (ld[F] && v_in[F])
                z_q[F] <= sum_in;
            for (int k = F + 1; k <= LAST; k++)
                if (ld[k] && v_in[k])
                    z_q[k] <= z_q[k-1];
        end
    end

`ifdef APPROX_SMUL_ERRSTAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++)
                e_q[k] <= '0;
        end else begin
            if (ld[0] && in_valid)
                e_q[0] <= err_in;
            for (int k = 1; k < STAGES; k++)
                if (ld[k] && v_in[k])
                    e_q[k] <= e_q[k-1];
        end
    end

    assign out_err = e_q[LAST];
    assign err_abs = e_q[LAST][PW-1] ? (~e_q[LAST] + PW'(1))
                                     : e_q[LAST];

    always_ff @(posedge clk) begin
        if (rst)
            err_max <= '0;
        else if (out_valid && out_ready && err_abs > err_max)
            err_max <= err_abs;
    end
`endif

endmodule
